// File: rtl/exec_mul_sequencer.sv
// Multi-cycle MUL/MLA sequencer for the Exec stage: a radix-2 shift-add engine.
// It holds the pipeline with a stall request and pulses done with the result and N/Z flags.
module exec_mul_sequencer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cond_ok_i,
  input  logic             accumulate_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic [Width-1:0] acc_in_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [Width-1:0] result_o,
  output logic             flag_n_o,
  output logic             flag_z_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] mcand_q, mcand_d;
  logic [Width-1:0] mplr_q, mplr_d;
  logic [Width-1:0] prod_q, prod_d;
  logic [Width-1:0] mplr_shifted;
  logic             issue;

  assign issue        = start_i & cond_ok_i;
  assign mplr_shifted = mplr_q >> 1;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    if (flush_i) begin
      // Abort: the partial product is left in place, only sequencing stops.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            mcand_d = op_a_i;
            mplr_d  = op_b_i;
            prod_d  = accumulate_i ? acc_in_i : '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (mplr_q[0]) begin
            prod_d = prod_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_shifted;
          if (mplr_shifted == '0) begin
            state_d = StDone;
          end
        end
        StDone: begin
          // The same instruction still drives start here, so it must not re-issue.
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
    end
  end

  assign stall_o  = ~flush_i & (((state_q == StIdle) & issue) | (state_q == StRun));
  assign done_o   = (state_q == StDone) & ~flush_i;
  assign result_o = prod_q;
  assign flag_n_o = prod_q[Width-1];
  assign flag_z_o = (prod_q == '0);

endmodule
